seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Multi-cycle signed restoring divider; inverse datapath to the team's sequential Booth multiplier.
//   Takes WIDTH-bit two's-complement Dividend/Divisor on Start; returns Quotient/Remainder with a Done pulse.
//   Sits beside the multiplier in the arithmetic unit and uses the same Start/Done handshake style.
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=4); iteration count equals WIDTH
// PORTS
//   clk        in   1      rising-edge clock; the only clock
//   Resetn     in   1      reset: synchronous, active-low
//   Start      in   1      sampled only while idle; launches one division
//   Dividend   in   WIDTH  signed; sampled on the Start edge
//   Divisor    in   WIDTH  signed; sampled on the Start edge
//   Busy       out  1      high from the Start edge until the Done edge
//   Done       out  1      one-cycle pulse; results valid from this cycle on
//   Quotient   out  WIDTH  signed; holds value until next Done
//   Remainder  out  WIDTH  signed; holds value until next Done
// BEHAVIOUR
//   Reset: Resetn=0 at any rising edge gives state=IDLE, Busy=0, Done=0, Quotient=0, Remainder=0, count=0.
//   Reset mid-operation aborts the division. No Done is produced.
//   FSM states: IDLE, CALC, FIX.
//   - IDLE: Start=1 at edge E0 latches |Dividend|, |Divisor|, both sign bits and a zero-divisor flag.
//     Clears partial remainder (WIDTH+1 bits) and count. Moves to CALC; Busy=1.
//   - CALC: one restoring step per edge, on edges E1..E_WIDTH.
//     - Shift {R,Q} left by 1 and form R-|D|.
//     - Result >= 0: keep it and set Q[0]=1. Otherwise restore R and set Q[0]=0.
//     - count increments each step. When count==WIDTH-1, go to FIX.
//   - FIX: at edge E_WIDTH+1, apply the sign rules below and register the outputs.
//     Set Done=1 and Busy=0, and return to IDLE.
//   Latency: Done is high in the cycle after edge E_(WIDTH+1), i.e. WIDTH+1 edges after Start.
//   Latency is fixed for all operands, including exceptions.
//   Sign rules: quotient truncates toward zero.
//   - Quotient is negated when the operand signs differ.
//   - Remainder takes the sign of Dividend, with |Remainder| < |Divisor|.
//   Magnitudes are held unsigned in WIDTH bits, so -2^(WIDTH-1) needs no extra bit.
//   Divide by zero: Quotient = all ones (-1), Remainder = Dividend.
//   Overflow (-2^(WIDTH-1) / -1): Quotient = -2^(WIDTH-1) (wraps), Remainder = 0.
//   Start asserted while Busy is ignored, with no queuing.
//   Start in the same cycle as Done is accepted, since the FSM is already IDLE: back-to-back operation.
//   Operand inputs may change freely after E0.
// CONFIGURATION
//   Macro DIV_EXCEPTION_EN:
//   - Defined: adds output ports DivByZero and Overflow (1 bit each, reset 0).
//     Both are registered with Done and hold until the next Done.
//   - Undefined: those ports do not exist.
//   Quotient/Remainder values are identical in both builds.
// STRUCTURE
//   Package div_pkg holds:
//   - state encoding localparams S_IDLE=2'b00, S_CALC=2'b01, S_FIX=2'b10
//   - DIV_WIDTH_DEFAULT=8
//   - helper function abs_mag(signed) -> unsigned WIDTH
//   Sub-module div_step is combinational and holds one restoring iteration:
//   - inputs: R (WIDTH+1), Q (WIDTH), Dmag (WIDTH)
//   - outputs: next R, next Q
//   The FSM, counter and sign-fix logic live in seq_divider.
// TESTING (WIDTH=8)
//   - 100 / 7 -> Quotient=14, Remainder=2.
//     Done exactly 9 edges after the Start edge; Busy high for 9 cycles.
//   - -100 / 7 -> Q=-14, R=-2.  100 / -7 -> Q=-14, R=2.  -100 / -7 -> Q=14, R=-2.
//   - -128 / -1 -> Q=-128 (0x80), R=0; Overflow=1 under DIV_EXCEPTION_EN.
//     -128 / 1 -> Q=-128, Overflow=0.
//   - 5 / 0 -> Q=0xFF, R=5; DivByZero=1 under DIV_EXCEPTION_EN. Latency is still 9 edges.
//   - Start 37/5, then hold Start high with new operands for 20 cycles:
//     - first Done gives Q=7, R=2.
//     - the second op launches only on the Done cycle.
//     - there is never more than one Done per 9 edges.
//   - Resetn=0 for one edge at CALC step 4 -> Busy=0, Done never pulses, outputs 0.
//     A fresh Start then gives correct results.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared state encoding, default width and magnitude helper for seq_divider
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } div_state_t;

  // Callers sign-extend into 64 bits and size-cast the result back down;
  // the most negative value maps to 2^(WIDTH-1), which fits unsigned in WIDTH bits.
  function automatic logic [63:0] abs_mag(input logic signed [63:0] v);
    return v[63] ? 64'(-v) : 64'(v);
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   R,
  input  logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] Dmag,
  output logic [WIDTH:0]   R_next,
  output logic [WIDTH-1:0] Q_next
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  always_comb begin
    shifted = {R, Q[WIDTH-1]};
    diff    = shifted - {2'b00, Dmag};
    // A set top bit means the trial subtraction went negative: restore.
    if (diff[WIDTH+1]) begin
      R_next = shifted[WIDTH:0];
      Q_next = {Q[WIDTH-2:0], 1'b0};
    end else begin
      R_next = diff[WIDTH:0];
      Q_next = {Q[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle signed restoring divider, Start/Done handshake
// Optional DivByZero/Overflow outputs when DIV_EXCEPTION_EN is defined.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                    clk,
  input  logic                    Resetn,
  input  logic                    Start,
  input  logic signed [WIDTH-1:0] Dividend,
  input  logic signed [WIDTH-1:0] Divisor,
  output logic                    Busy,
  output logic                    Done,
`ifdef DIV_EXCEPTION_EN
  output logic                    DivByZero,
  output logic                    Overflow,
`endif
  output logic signed [WIDTH-1:0] Quotient,
  output logic signed [WIDTH-1:0] Remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r_acc;
  logic [WIDTH-1:0] q_acc;
  logic [WIDTH-1:0] d_mag;
  logic [WIDTH-1:0] dvd;
  logic             sign_a;
  logic             sign_b;
  logic             dz;
  logic             ovf;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  div_step #(.WIDTH(WIDTH)) u_step (
    .R      (r_acc),
    .Q      (q_acc),
    .Dmag   (d_mag),
    .R_next (r_next),
    .Q_next (q_next)
  );

  always_ff @(posedge clk) begin
    if (!Resetn) begin
      state     <= S_IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Quotient  <= '0;
      Remainder <= '0;
      count     <= '0;
      r_acc     <= '0;
      q_acc     <= '0;
      d_mag     <= '0;
      dvd       <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dz        <= 1'b0;
      ovf       <= 1'b0;
`ifdef DIV_EXCEPTION_EN
      DivByZero <= 1'b0;
      Overflow  <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start) begin
            q_acc  <= WIDTH'(abs_mag(64'(Dividend)));
            d_mag  <= WIDTH'(abs_mag(64'(Divisor)));
            dvd    <= Dividend;
            sign_a <= Dividend[WIDTH-1];
            sign_b <= Divisor[WIDTH-1];
            dz     <= (Divisor == '0);
            ovf    <= (Dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (Divisor == '1);
            r_acc  <= '0;
            count  <= '0;
            Busy   <= 1'b1;
            state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_acc <= r_next;
          q_acc <= q_next;
          count <= count + CW'(1);
          if (count == LAST) state <= S_FIX;
        end
        S_FIX: begin
          // Divide-by-zero overrides the datapath; overflow wraps naturally.
          if (dz) begin
            Quotient  <= '1;
            Remainder <= dvd;
          end else begin
            Quotient  <= (sign_a ^ sign_b) ? -q_acc : q_acc;
            Remainder <= sign_a ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
          end
`ifdef DIV_EXCEPTION_EN
          DivByZero <= dz;
          Overflow  <= ovf;
`endif
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - directed self-checking bench for seq_divider (WIDTH=8)
module tb_seq_divider;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       Start;
  logic [7:0] Dividend;
  logic [7:0] Divisor;
  logic       Busy;
  logic       Done;
  logic [7:0] Quotient;
  logic [7:0] Remainder;
`ifdef DIV_EXCEPTION_EN
  logic       DivByZero;
  logic       Overflow;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_divider #(.WIDTH(8)) dut (
    .clk       (clk),
    .Resetn    (Resetn),
    .Start     (Start),
    .Dividend  (Dividend),
    .Divisor   (Divisor),
    .Busy      (Busy),
    .Done      (Done),
`ifdef DIV_EXCEPTION_EN
    .DivByZero (DivByZero),
    .Overflow  (Overflow),
`endif
    .Quotient  (Quotient),
    .Remainder (Remainder)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[13] = '{
    '{8'd100, 8'd7,   8'd14,  8'd2,   1'b0, 1'b0},
    '{8'h9C,  8'd7,   8'hF2,  8'hFE,  1'b0, 1'b0},
    '{8'd100, 8'hF9,  8'hF2,  8'd2,   1'b0, 1'b0},
    '{8'h9C,  8'hF9,  8'd14,  8'hFE,  1'b0, 1'b0},
    '{8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, 1'b1},
    '{8'h80,  8'd1,   8'h80,  8'd0,   1'b0, 1'b0},
    '{8'd5,   8'd0,   8'hFF,  8'd5,   1'b1, 1'b0},
    '{8'hF9,  8'd0,   8'hFF,  8'hF9,  1'b1, 1'b0},
    '{8'h7F,  8'h7F,  8'd1,   8'd0,   1'b0, 1'b0},
    '{8'd3,   8'd7,   8'd0,   8'd3,   1'b0, 1'b0},
    '{8'h80,  8'h80,  8'd1,   8'd0,   1'b0, 1'b0},
    '{8'hFF,  8'd2,   8'd0,   8'hFF,  1'b0, 1'b0},
    '{8'd37,  8'd5,   8'd7,   8'd2,   1'b0, 1'b0}
  };

  int lat;
  int busy_cyc;

  // Launch one division and wait (bounded) for Done; lat counts edges after E0.
  task automatic do_div(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    Dividend = a;
    Divisor  = b;
    Start    = 1'b1;
    @(posedge clk);
    #1;
    Start    = 1'b0;
    Dividend = 8'($urandom);
    Divisor  = 8'($urandom);
    lat      = 0;
    busy_cyc = 0;
    while (lat < 30) begin
      @(negedge clk);
      if (Done) break;
      if (Busy) busy_cyc++;
      @(posedge clk);
      lat++;
    end
  endtask

  int ndone;
  int first_e;
  int second_e;
  logic [7:0] q1, r1, q2, r2;
  logic busy10;
  int spurious;

  initial begin
    Resetn   = 1'b0;
    Start    = 1'b0;
    Dividend = '0;
    Divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", Busy, 0);
    check("reset_done", Done, 0);
    check("reset_q", Quotient, 0);
    check("reset_r", Remainder, 0);
    Resetn = 1'b1;

    foreach (vecs[i]) begin
      do_div(vecs[i].a, vecs[i].b);
      check($sformatf("lat_%0d", i), lat, 9);
      check($sformatf("busycyc_%0d", i), busy_cyc, 9);
      check($sformatf("busy_at_done_%0d", i), Busy, 0);
      check($sformatf("q_%0d", i), Quotient, vecs[i].q);
      check($sformatf("r_%0d", i), Remainder, vecs[i].r);
`ifdef DIV_EXCEPTION_EN
      check($sformatf("dz_%0d", i), DivByZero, vecs[i].dz);
      check($sformatf("ov_%0d", i), Overflow, vecs[i].ov);
`endif
      @(negedge clk);
      check($sformatf("done_pulse_%0d", i), Done, 0);
      check($sformatf("q_hold_%0d", i), Quotient, vecs[i].q);
    end

    // Start held high for 20 edges: only the Done cycle may relaunch.
    @(negedge clk);
    Start    = 1'b1;
    Dividend = 8'd37;
    Divisor  = 8'd5;
    @(posedge clk);
    #1;
    Dividend = 8'd50;
    Divisor  = 8'd3;
    ndone = 0; first_e = 0; second_e = 0;
    q1 = '0; r1 = '0; q2 = '0; r2 = '0; busy10 = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 19) Start = 1'b0;
      if (e == 10) busy10 = Busy;
      if (Done) begin
        ndone++;
        if (ndone == 1) begin first_e = e; q1 = Quotient; r1 = Remainder; end
        else if (ndone == 2) begin second_e = e; q2 = Quotient; r2 = Remainder; end
      end
    end
    check("b2b_ndone", ndone, 2);
    check("b2b_first_edge", first_e, 9);
    check("b2b_second_edge", second_e, 19);
    check("b2b_q1", q1, 7);
    check("b2b_r1", r1, 2);
    check("b2b_busy_relaunch", busy10, 1);
    check("b2b_q2", q2, 16);
    check("b2b_r2", r2, 2);

    // Reset during CALC step 4 aborts with no Done.
    @(negedge clk);
    Start    = 1'b1;
    Dividend = 8'd100;
    Divisor  = 8'd7;
    @(posedge clk);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    Resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    Resetn = 1'b1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_q", Quotient, 0);
    check("abort_r", Remainder, 0);
    spurious = 0;
    repeat (15) begin
      @(negedge clk);
      if (Done || Busy) spurious++;
    end
    check("abort_no_done", spurious, 0);

    do_div(8'h9C, 8'd7);
    check("post_abort_lat", lat, 9);
    check("post_abort_q", Quotient, 8'hF2);
    check("post_abort_r", Remainder, 8'hFE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
